// File: rtl/conv_layer_sequencer.sv
// Layer sequencer for the IMG2COL_GEMM engine: queues layer descriptors, validates them,
// runs the engine one layer at a time with a watchdog, an abort path and a fixed quiet gap.
module conv_layer_sequencer #(
    parameter int TW         = 8,
    parameter int KW         = 4,
    parameter int CW         = 8,
    parameter int SW         = 4,
    parameter int NW         = 8,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [TW-1:0]              cfg_tensor_size,
    input  logic [KW-1:0]              cfg_kernel_size,
    input  logic [CW-1:0]              cfg_channels,
    input  logic [SW-1:0]              cfg_stride,
    input  logic [NW-1:0]              cfg_kernel_nums,
    input  logic                       abort,
    input  logic                       eng_w_done,
    output logic                       eng_enable,
    output logic [TW-1:0]              eng_tensor_size,
    output logic [KW-1:0]              eng_kernel_size,
    output logic [CW-1:0]              eng_channels,
    output logic [SW-1:0]              eng_stride,
    output logic [NW-1:0]              eng_kernel_nums,
    output logic                       busy,
    output logic                       layer_done,
    output logic                       layer_err,
    output logic [1:0]                 err_code,
    output logic                       abort_ack,
    output logic [15:0]                layer_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int MW = (TW > KW) ? TW : KW;
    localparam logic [19:0]   RUN_LAST = 20'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_e;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [KW-1:0] k;
        logic [CW-1:0] c;
        logic [SW-1:0] s;
        logic [NW-1:0] n;
    } desc_t;

    desc_t mem [DEPTH];
    desc_t desc_in;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    desc_t         desc_q, desc_d;
    logic          en_q, en_d;
    logic [19:0]   run_cnt_q, run_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          done_q, done_d, err_q, err_d, ack_q, ack_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          abort_pend_q, abort_pend_d;
    logic [15:0]   layer_cnt_q, layer_cnt_d;

    logic push, pop, invalid;

    assign desc_in = {cfg_tensor_size, cfg_kernel_size, cfg_channels, cfg_stride, cfg_kernel_nums};
    assign push    = cfg_valid && cfg_ready && !abort;
    assign pop     = (state_q == IDLE) && (level_q != '0) && !abort;
    assign invalid = (desc_q.k == '0) || (desc_q.s == '0) || (desc_q.c == '0) ||
                     (desc_q.n == '0) || (MW'(desc_q.k) > MW'(desc_q.t));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d      = level_q + LW'(push) - LW'(pop);
        desc_d       = desc_q;
        en_d         = en_q;
        run_cnt_d    = run_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ack_d        = 1'b0;
        err_code_d   = err_code_q;
        abort_pend_d = abort_pend_q;
        layer_cnt_d  = layer_cnt_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    desc_d  = mem[rd_ptr_q];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (invalid) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end else begin
                    en_d      = 1'b1;
                    run_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // w_done takes priority over a watchdog expiry in the same cycle
                if (eng_w_done) begin
                    done_d      = 1'b1;
                    layer_cnt_d = layer_cnt_q + 16'd1;
                    en_d        = 1'b0;
                    gap_cnt_d   = '0;
                    state_d     = GAP;
                end else if (run_cnt_q == RUN_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    en_d       = 1'b0;
                    gap_cnt_d  = '0;
                    state_d    = GAP;
                end else begin
                    run_cnt_d = run_cnt_q + 20'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d      = IDLE;
                    ack_d        = abort_pend_q;
                    abort_pend_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything: flush, drop the engine, suppress this layer's pulses.
        if (abort) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            desc_d       = desc_q;
            en_d         = 1'b0;
            done_d       = 1'b0;
            err_d        = 1'b0;
            ack_d        = 1'b0;
            err_code_d   = err_code_q;
            layer_cnt_d  = layer_cnt_q;
            gap_cnt_d    = '0;
            abort_pend_d = 1'b1;
            state_d      = GAP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            desc_q       <= '0;
            en_q         <= 1'b0;
            run_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            err_code_q   <= 2'b00;
            abort_pend_q <= 1'b0;
            layer_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            desc_q       <= desc_d;
            en_q         <= en_d;
            run_cnt_q    <= run_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            err_code_q   <= err_code_d;
            abort_pend_q <= abort_pend_d;
            layer_cnt_q  <= layer_cnt_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= desc_in;
    end

    assign cfg_ready       = (level_q != LW'(DEPTH));
    assign fifo_level      = level_q;
    assign busy            = (state_q != IDLE) || (level_q != '0);
    assign eng_enable      = en_q;
    assign eng_tensor_size = desc_q.t;
    assign eng_kernel_size = desc_q.k;
    assign eng_channels    = desc_q.c;
    assign eng_stride      = desc_q.s;
    assign eng_kernel_nums = desc_q.n;
    assign layer_done      = done_q;
    assign layer_err       = err_q;
    assign err_code        = err_code_q;
    assign abort_ack       = ack_q;
    assign layer_cnt       = layer_cnt_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: directed layers, engine responder, and
// monitors checking status pulses and each enable window against queued expectations.
module tb_conv_layer_sequencer;
    localparam int GAP = 4;
    localparam int TO  = 100;
    localparam int EV_DONE = 0, EV_ERR = 1, EV_ACK = 2;

    typedef struct { int kind; logic [1:0] code; logic [31:0] cfg; int cnt; } ev_t;
    typedef struct { int dur; logic [31:0] cfg; } run_t;

    logic clk = 0, rstn = 0, cfg_valid = 0, abort = 0;
    logic [7:0] cfg_tensor_size = 0, cfg_channels = 0, cfg_kernel_nums = 0;
    logic [3:0] cfg_kernel_size = 0, cfg_stride = 0;
    logic wd_resp = 0, wd_stim = 0, eng_w_done;
    logic cfg_ready, eng_enable, busy, layer_done, layer_err, abort_ack;
    logic [7:0] eng_tensor_size, eng_channels, eng_kernel_nums;
    logic [3:0] eng_kernel_size, eng_stride;
    logic [1:0] err_code;
    logic [15:0] layer_cnt;
    logic [2:0] fifo_level;
    logic [31:0] cur_cfg;

    int tests = 0, fails = 0;
    ev_t  ev_q[$];
    run_t run_q[$];
    int   plan_q[$];

    assign eng_w_done = wd_resp | wd_stim;
    assign cur_cfg = {eng_tensor_size, eng_kernel_size, eng_channels, eng_stride, eng_kernel_nums};

    always #5 clk = ~clk;

    conv_layer_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
        .cfg_channels(cfg_channels), .cfg_stride(cfg_stride), .cfg_kernel_nums(cfg_kernel_nums),
        .abort(abort), .eng_w_done(eng_w_done), .eng_enable(eng_enable),
        .eng_tensor_size(eng_tensor_size), .eng_kernel_size(eng_kernel_size),
        .eng_channels(eng_channels), .eng_stride(eng_stride), .eng_kernel_nums(eng_kernel_nums),
        .busy(busy), .layer_done(layer_done), .layer_err(layer_err), .err_code(err_code),
        .abort_ack(abort_ack), .layer_cnt(layer_cnt), .fifo_level(fifo_level)
    );

    function automatic logic [31:0] D(int t, int k, int c, int s, int n);
        return {8'(t), 4'(k), 8'(c), 4'(s), 8'(n)};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_ev(int kind, logic [1:0] code, logic [31:0] cfg, int cnt);
        ev_t e;
        e.kind = kind; e.code = code; e.cfg = cfg; e.cnt = cnt;
        ev_q.push_back(e);
    endtask

    task automatic exp_run(int dur, logic [31:0] cfg, int plan);
        run_t r;
        r.dur = dur; r.cfg = cfg;
        run_q.push_back(r);
        plan_q.push_back(plan);
    endtask

    // Event monitor: every status pulse must match the head of the expectation queue.
    task automatic mon_ev(int k, logic [1:0] code);
        ev_t e;
        tests++;
        if (ev_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: got kind %0d expected none", k);
            return;
        end
        tests--;
        e = ev_q.pop_front();
        chk("ev_kind", k, e.kind);
        if (k == EV_ERR) chk("err_code", code, e.code);
        if (k != EV_ACK) chk("ev_cfg", cur_cfg, e.cfg);
        chk("ev_layer_cnt", layer_cnt, e.cnt);
    endtask

    always @(negedge clk) if (rstn) begin
        if (layer_done) mon_ev(EV_DONE, 2'b00);
        if (layer_err)  mon_ev(EV_ERR, err_code);
        if (abort_ack)  mon_ev(EV_ACK, 2'b00);
    end

    // Enable-window monitor: length, config at rise, config stability, and low spacing.
    int hi_cnt = 0, lo_cnt = 0;
    bit seen_fall = 0, stable = 1;
    logic [31:0] rise_cfg = 0;

    task automatic end_run();
        run_t r;
        tests++;
        if (run_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_enable: got cfg %0h expected no run", rise_cfg);
            return;
        end
        tests--;
        r = run_q.pop_front();
        chk("run_cfg", rise_cfg, r.cfg);
        if (r.dur >= 0) chk("run_len", hi_cnt, r.dur);
        chk("cfg_stable", stable, 1);
    endtask

    always @(negedge clk) begin
        if (eng_enable) begin
            if (hi_cnt == 0) begin
                rise_cfg = cur_cfg;
                stable = 1;
                if (seen_fall) begin
                    tests++;
                    if (lo_cnt < GAP + 2) begin
                        fails++;
                        $display("FAIL enable_spacing: got %0d low cycles expected >= %0d", lo_cnt, GAP + 2);
                    end
                end
            end else if (cur_cfg !== rise_cfg) stable = 0;
            hi_cnt++;
        end else begin
            if (hi_cnt != 0) begin
                end_run();
                seen_fall = 1;
                lo_cnt = 0;
            end
            hi_cnt = 0;
            lo_cnt++;
        end
    end

    // Engine model: asserts w_done on the planned high cycle of each enable window (0 = never).
    initial begin : responder
        int n, h;
        bit act;
        n = 0; h = 0; act = 0;
        forever begin
            @(negedge clk);
            wd_resp = 0;
            if (eng_enable) begin
                if (!act) begin
                    act = 1; h = 0;
                    n = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
                end
                h++;
                if (n != 0 && h == n) wd_resp = 1;
            end else act = 0;
        end
    end

    task automatic push(logic [31:0] d);
        {cfg_tensor_size, cfg_kernel_size, cfg_channels, cfg_stride, cfg_kernel_nums} = d;
        cfg_valid = 1;
        for (int i = 0; i < 2000 && !cfg_ready; i++) @(negedge clk);
        if (!cfg_ready) begin
            tests++; fails++;
            $display("FAIL push_wait: got cfg_ready 0 expected 1 within bound");
        end
        @(negedge clk);
        cfg_valid = 0;
    endtask

    task automatic wait_en(logic v);
        for (int i = 0; i < 2000 && eng_enable !== v; i++) @(negedge clk);
        if (eng_enable !== v) begin
            tests++; fails++;
            $display("FAIL wait_enable: got %0b expected %0b within bound", eng_enable, v);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        if (busy) begin
            tests++; fails++;
            $display("FAIL wait_idle: got busy 1 expected 0 within bound");
        end
    endtask

    logic [31:0] a, p, bad, good, t, l1, l2, l3, w;
    logic [31:0] dq[5];
    logic [31:0] inv[4];

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_enable", eng_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_layer_cnt", layer_cnt, 0);
        chk("rst_pulses", {layer_done, layer_err, abort_ack, err_code}, 0);
        chk("rst_cfg", cur_cfg, 0);
        rstn = 1;
        @(negedge clk);

        // Single layer, 50-cycle run, then exact 4-cycle gap.
        a = D(8, 3, 1, 1, 2);
        exp_run(50, a, 50);
        exp_ev(EV_DONE, 2'b00, a, 1);
        push(a);
        wait_en(1);
        wait_en(0);
        repeat (3) @(negedge clk);
        chk("gap_busy_last", busy, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("t1_layer_cnt", layer_cnt, 1);

        // Fill the FIFO while a layer runs; held 5th push enters after the first pop.
        p = D(10, 3, 2, 1, 4);
        dq[0] = D(9, 2, 1, 1, 1);  dq[1] = D(9, 3, 2, 2, 2);  dq[2] = D(20, 4, 3, 3, 3);
        dq[3] = D(5, 5, 4, 1, 6);  dq[4] = D(7, 1, 1, 1, 7);
        exp_run(30, p, 30);
        exp_ev(EV_DONE, 2'b00, p, 2);
        for (int i = 0; i < 5; i++) begin
            exp_run(5, dq[i], 5);
            exp_ev(EV_DONE, 2'b00, dq[i], 3 + i);
        end
        push(p);
        wait_en(1);
        for (int i = 0; i < 4; i++) push(dq[i]);
        chk("full_level", fifo_level, 4);
        chk("full_ready", cfg_ready, 0);
        push(dq[4]);
        wait_idle();
        chk("t2_layer_cnt", layer_cnt, 7);

        // Invalid descriptors are rejected without enabling; the following layer runs.
        inv[0] = D(4, 5, 1, 1, 1); inv[1] = D(8, 0, 1, 1, 1);
        inv[2] = D(8, 2, 0, 1, 1); inv[3] = D(8, 2, 1, 0, 1);
        bad = D(8, 2, 1, 1, 0);
        good = D(16, 3, 3, 1, 8);
        for (int i = 0; i < 4; i++) exp_ev(EV_ERR, 2'b01, inv[i], 7);
        exp_ev(EV_ERR, 2'b01, bad, 7);
        exp_run(7, good, 7);
        exp_ev(EV_DONE, 2'b00, good, 8);
        for (int i = 0; i < 4; i++) push(inv[i]);
        push(bad);
        push(good);
        wait_idle();

        // Watchdog: 100 RUN cycles, then a stray w_done in GAP is ignored.
        t = D(8, 2, 4, 2, 3);
        exp_run(TO, t, 0);
        exp_ev(EV_ERR, 2'b10, t, 8);
        push(t);
        wait_en(1);
        wait_en(0);
        @(negedge clk);
        wd_stim = 1;
        @(negedge clk);
        wd_stim = 0;
        wait_idle();
        chk("t4_layer_cnt", layer_cnt, 8);

        // Abort 10 cycles into RUN with two queued; coincident push discarded.
        l1 = D(6, 3, 1, 1, 1); l2 = D(6, 2, 1, 1, 2); l3 = D(6, 1, 1, 1, 3);
        exp_run(10, l1, 0);
        exp_ev(EV_ACK, 2'b00, 0, 8);
        push(l1); push(l2); push(l3);
        wait_en(1);
        repeat (9) @(negedge clk);
        chk("pre_abort_level", fifo_level, 2);
        {cfg_tensor_size, cfg_kernel_size, cfg_channels, cfg_stride, cfg_kernel_nums} = D(9, 1, 1, 1, 1);
        cfg_valid = 1;
        abort = 1;
        @(negedge clk);
        abort = 0;
        cfg_valid = 0;
        chk("abort_enable", eng_enable, 0);
        chk("abort_level", fifo_level, 0);
        repeat (3) @(negedge clk);
        chk("abort_ack_early", abort_ack, 0);
        @(negedge clk);
        chk("abort_ack", abort_ack, 1);
        chk("abort_idle", busy, 0);

        // w_done on the timeout cycle wins.
        w = D(12, 4, 2, 3, 5);
        exp_run(TO, w, TO);
        exp_ev(EV_DONE, 2'b00, w, 9);
        push(w);
        wait_idle();
        chk("t5_layer_cnt", layer_cnt, 9);

        // Asynchronous reset mid-RUN with two entries queued.
        exp_run(-1, D(8, 3, 1, 1, 1), 0);
        push(D(8, 3, 1, 1, 1)); push(D(8, 2, 1, 1, 1)); push(D(8, 1, 1, 1, 1));
        wait_en(1);
        repeat (5) @(negedge clk);
        #2 rstn = 0;
        #1;
        chk("arst_enable", eng_enable, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_layer_cnt", layer_cnt, 0);
        @(negedge clk);
        rstn = 1;
        repeat (30) @(negedge clk);
        chk("post_rst_enable", eng_enable, 0);
        chk("post_rst_busy", busy, 0);

        chk("ev_queue_drained", ev_q.size(), 0);
        chk("run_queue_drained", run_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences the IMG2COL_GEMM convolution engine over a queue of layer descriptors.
- Each descriptor carries tensor_size, kernel_size, channels, stride and kernel_nums. The block buffers descriptors in a small FIFO and validates each one.
- For each valid descriptor it drives the engine configuration and enable, waits for the engine's w_done, then enforces a quiet gap before starting the next layer.
- Also provides a watchdog timeout, an abort path and per-layer status pulses.

Parameters:
- TW, 8: tensor_size width (matches `TENSOR_SIZE).
- KW, 4: kernel_size width (matches `KERNEL_SIZE).
- CW, 8: channels width (matches `CHANNELS_SIZE).
- SW, 4: stride width (matches `STRIDE_SIZE).
- NW, 8: kernel_nums width (matches `KERNEL_NUMS_SIZE).
- DEPTH, 4: descriptor FIFO entries (power of 2, ≥2).
- GAP_CYCLES, 4: cycles eng_enable is held low between layers (≥1).
- TIMEOUT, 65535: maximum RUN cycles before a layer is declared hung (<2^20).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cfg_valid  in  1  descriptor push request
- cfg_ready  out  1  FIFO not full
- cfg_tensor_size  in  TW  descriptor field
- cfg_kernel_size  in  KW  descriptor field
- cfg_channels  in  CW  descriptor field
- cfg_stride  in  SW  descriptor field
- cfg_kernel_nums  in  NW  descriptor field
- abort  in  1  flush queue and stop the engine
- eng_w_done  in  1  engine write-back complete pulse
- eng_enable  out  1  engine enable
- eng_tensor_size / eng_kernel_size / eng_channels / eng_stride / eng_kernel_nums  out  TW/KW/CW/SW/NW  engine configuration
- busy  out  1  state ≠ IDLE or FIFO non-empty
- layer_done  out  1  one-cycle pulse, layer completed
- layer_err  out  1  one-cycle pulse, layer rejected or timed out
- err_code  out  2  01 = invalid descriptor, 10 = timeout; valid on layer_err
- abort_ack  out  1  one-cycle pulse, abort completed
- layer_cnt  out  16  count of completed layers, wraps
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset state: all outputs 0, FIFO empty, state IDLE, except cfg_ready = 1.
- Push: a descriptor is written when cfg_valid && cfg_ready. cfg_ready = !full (registered occupancy).
  - Push and pop in the same cycle are allowed; the level is unchanged.
  - Push while full is dropped with no state change.
- FSM states: IDLE, LOAD, RUN, GAP.
- IDLE: when FIFO non-empty, pop the head and latch it into the eng_* registers; next state LOAD.
- LOAD (1 cycle): validate the latched descriptor. Invalid if any of:
  - kernel_size == 0
  - stride == 0
  - channels == 0
  - kernel_nums == 0
  - kernel_size > tensor_size

  Result:
  - Invalid: layer_err = 1 with err_code = 01, then go to GAP. eng_enable is never asserted for this descriptor.
  - Valid: eng_enable = 1 from the next cycle; go to RUN and clear the run counter.
- RUN: eng_enable held at 1; the run counter increments every cycle.
  - eng_w_done = 1: layer_done pulse next cycle, layer_cnt + 1, eng_enable = 0 next cycle, go to GAP.
  - Run counter == TIMEOUT−1 with no w_done: layer_err with err_code = 10, eng_enable = 0 next cycle, go to GAP.
  - If w_done and timeout occur in the same cycle, w_done wins.
- GAP: eng_enable = 0 for exactly GAP_CYCLES cycles, then IDLE.
  - eng_* configuration is held stable from the LOAD cycle until GAP exits. It must not change while eng_enable = 1.
- eng_w_done outside RUN is ignored.
- abort (sampled each cycle, any state):
  - FIFO flushed, eng_enable = 0 next cycle, state → GAP.
  - abort_ack pulses when GAP exits.
  - No layer_done and no layer_err for the aborted layer.
  - A push coincident with abort is discarded.
  - abort while already in GAP restarts the gap count.
- Back-to-back layers: minimum spacing between eng_enable falling and the next rising edge is GAP_CYCLES + 2 (IDLE + LOAD).
- Asynchronous reset mid-RUN: eng_enable drops immediately, the FIFO is emptied, and no pulses are issued.

Test Plan:
- Push one descriptor (8,3,1,1,2); w_done asserted 50 cycles after eng_enable rises → eng_enable high exactly 50 cycles, eng_* = (8,3,1,1,2), layer_done one pulse, layer_cnt = 1, GAP of 4 cycles, then IDLE and busy = 0.
- Push 4 descriptors back-to-back, then a 5th with cfg_valid held → cfg_ready = 0 at level 4; the 5th is accepted once the first pop occurs; all 5 run in push order with ≥ GAP_CYCLES+2 low cycles between enables.
- Descriptor with kernel_size = 5, tensor_size = 4 → layer_err with err_code = 01 the cycle after LOAD, eng_enable never high, the next queued layer runs normally.
- TIMEOUT = 100 override, w_done withheld → layer_err with err_code = 10 after 100 RUN cycles, eng_enable low the next cycle, layer_cnt unchanged; a w_done arriving later in GAP is ignored.
- 3 layers queued, abort asserted 10 cycles into RUN → eng_enable low next cycle, fifo_level = 0, abort_ack after 4 GAP cycles, no layer_done; w_done asserted simultaneously with the timeout cycle → layer_done only.
- rstn pulled low mid-RUN with 2 entries queued → eng_enable = 0 asynchronously, fifo_level = 0, cfg_ready = 1, and no pulses after release.
